// File: rtl/rv32_flash_pkg.sv
// Shared types and constants for the SPI flash read controller.
// Holds the FSM state encoding, the read command and the transfer sizes.
package rv32_flash_pkg;
    typedef enum logic [2:0] {IDLE, CMD, DATA, DONE, HOLD, DESEL} state_t;

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam int         CMD_BITS  = 32;
    localparam int         DATA_BITS = 32;

    // Flash streams bytes in address order; the bus expects byte 0 in the low lane.
    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction
endpackage

// File: rtl/rv32_spi_shift.sv
// SPI mode-0 shift engine: clock divider, bit counter and one 32-bit shift register.
// A start pulse loads a word; exactly DATA_BITS bit-times follow, back-to-back starts allowed.
module rv32_spi_shift
    import rv32_flash_pkg::*;
#(
    parameter int CLK_DIV = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 tx_en,
    input  logic [DATA_BITS-1:0] load,
    input  logic                 miso,
    output logic                 sck,
    output logic                 mosi,
    output logic                 last,
    output logic [DATA_BITS-1:0] rx_word
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_MAX = BW'(DATA_BITS - 1);

    logic                 busy, phase, tx_q, miso_q, half_end;
    logic [DW-1:0]        div_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;

    assign half_end = busy && (div_cnt == DIV_MAX);
    assign last     = half_end && phase && (bit_cnt == BIT_MAX);
    assign sck      = busy & phase;
    assign mosi     = busy & tx_q & shreg[DATA_BITS-1];
    // The final sampled bit is still in miso_q during the last cycle, so merge it here.
    assign rx_word  = {shreg[DATA_BITS-2:0], miso_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy    <= 1'b0;
            phase   <= 1'b0;
            tx_q    <= 1'b0;
            miso_q  <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else if (start) begin
            busy    <= 1'b1;
            phase   <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= load;
            tx_q    <= tx_en;
        end else if (busy) begin
            if (half_end) begin
                div_cnt <= '0;
                phase   <= ~phase;
                if (!phase) begin
                    miso_q <= miso;
                end else begin
                    // Falling edge: advance mosi and commit the bit sampled on the rise.
                    shreg   <= {shreg[DATA_BITS-2:0], miso_q};
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == BIT_MAX) busy <= 1'b0;
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/rv32_spi_flash_ctrl.sv
// Memory-mapped read-only SPI flash controller for a picorv32-style bus.
// Keeps CS asserted after a read so a following sequential word skips the command phase.
module rv32_spi_flash_ctrl
    import rv32_flash_pkg::*;
#(
    parameter int          CLK_DIV     = 1,
    parameter logic [31:0] FLASH_BASE  = 32'h0000_0000,
    parameter int          HOLD_CYCLES = 16,
    parameter int          CSB_HIGH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,
    output logic        mem_rdy,
    output logic        flash_csb,
    output logic        flash_clk,
    output logic        flash_mosi,
    input  logic        flash_miso
);
    state_t                state, state_n;
    logic                  done_hold, dh_n;
    logic [21:0]           last_addr;
    logic [15:0]           cnt;
    logic                  hit, is_wr, seq;
    logic                  sh_start, sh_tx, sh_last, set_addr, cap, cnt_clr, cnt_inc;
    logic [DATA_BITS-1:0]  sh_load, rx_word;
    logic [CMD_BITS-1:0]   cmd_word;
    logic                  unused;

    assign unused   = ^{mem_instr, mem_wdata, mem_addr[1:0]};
    assign hit      = mem_valid && (mem_addr[31:24] == FLASH_BASE[31:24]);
    assign is_wr    = |mem_wstrb;
    assign seq      = (mem_addr[23:2] == last_addr + 22'd1);
    assign cmd_word = {CMD_READ, mem_addr[23:2], 2'b00};

    assign mem_rdy   = (state == DONE);
    assign flash_csb = !(state == CMD || state == DATA || state == HOLD ||
                         (state == DONE && done_hold));

    rv32_spi_shift #(.CLK_DIV(CLK_DIV)) u_shift (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (sh_start),
        .tx_en   (sh_tx),
        .load    (sh_load),
        .miso    (flash_miso),
        .sck     (flash_clk),
        .mosi    (flash_mosi),
        .last    (sh_last),
        .rx_word (rx_word)
    );

    always_comb begin
        state_n  = state;
        dh_n     = done_hold;
        sh_start = 1'b0;
        sh_tx    = 1'b0;
        sh_load  = '0;
        set_addr = 1'b0;
        cap      = 1'b0;
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b0;
        case (state)
            IDLE: if (hit) begin
                if (is_wr) begin
                    state_n = DONE;
                    dh_n    = 1'b0;
                end else begin
                    state_n  = CMD;
                    sh_start = 1'b1;
                    sh_tx    = 1'b1;
                    sh_load  = cmd_word;
                    set_addr = 1'b1;
                end
            end
            CMD: if (sh_last) begin
                state_n  = DATA;
                sh_start = 1'b1;
            end
            DATA: if (sh_last) begin
                state_n = DONE;
                cap     = 1'b1;
                dh_n    = 1'b1;
            end
            DONE: begin
                state_n = done_hold ? HOLD : IDLE;
                cnt_clr = 1'b1;
            end
            HOLD: begin
                if (hit && is_wr) begin
                    state_n = DONE;
                    dh_n    = 1'b1;
                end else if (hit && seq) begin
                    state_n  = DATA;
                    sh_start = 1'b1;
                    set_addr = 1'b1;
                end else if (hit || cnt == 16'(HOLD_CYCLES - 1)) begin
                    state_n = DESEL;
                    cnt_clr = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            // The IDLE acceptance cycle also has CS high, so DESEL supplies the remainder.
            DESEL: begin
                if (32'(cnt) + 32'd2 >= 32'(CSB_HIGH)) begin
                    state_n = IDLE;
                    cnt_clr = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            done_hold <= 1'b0;
            last_addr <= '0;
            cnt       <= '0;
            mem_rdata <= '0;
        end else begin
            state     <= state_n;
            done_hold <= dh_n;
            if (set_addr) last_addr <= mem_addr[23:2];
            if (cnt_clr) cnt <= '0;
            else if (cnt_inc) cnt <= cnt + 16'd1;
            if (cap) mem_rdata <= bswap32(rx_word);
        end
    end
endmodule

// File: tb/tb_rv32_spi_flash_ctrl.sv
// Directed bench for rv32_spi_flash_ctrl with a behavioural SPI flash model and a scoreboard queue.
module tb_rv32_spi_flash_ctrl;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        mem_valid = 1'b0, mem_instr = 1'b0;
    logic [31:0] mem_addr = '0, mem_wdata = '0;
    logic [3:0]  mem_wstrb = '0;
    logic [31:0] mem_rdata;
    logic        mem_rdy, flash_csb, flash_clk, flash_mosi;
    logic        flash_miso = 1'b0;

    int total = 0, bad = 0;
    int csb_hi, csb_lo, n_cyc;

    typedef struct { logic [31:0] data; int lat; bit rd; } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    rv32_spi_flash_ctrl #(.CLK_DIV(1), .FLASH_BASE(32'h0), .HOLD_CYCLES(16), .CSB_HIGH(2)) dut (
        .clk(clk), .rst_n(rst_n), .mem_valid(mem_valid), .mem_instr(mem_instr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata), .mem_rdy(mem_rdy), .flash_csb(flash_csb),
        .flash_clk(flash_clk), .flash_mosi(flash_mosi), .flash_miso(flash_miso)
    );

    function automatic logic [7:0] fbyte(input logic [23:0] a);
        case (a)
            24'h000100: return 8'h11;
            24'h000101: return 8'h22;
            24'h000102: return 8'h33;
            24'h000103: return 8'h44;
            default:    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'hA5;
        endcase
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] addr);
        logic [23:0] a;
        a = addr[23:0] & 24'hFFFFFC;
        return {fbyte(a + 24'd3), fbyte(a + 24'd2), fbyte(a + 24'd1), fbyte(a)};
    endfunction

    // Flash model: command captured on rising SCK, data driven on falling SCK, streaming on.
    logic [31:0] cmd_sr = '0;
    int          bitcnt = 0;
    int          mk;
    logic [23:0] ma;
    logic [7:0]  mb;
    always @(negedge flash_csb) bitcnt = 0;
    always @(posedge flash_clk) if (!flash_csb) begin
        if (bitcnt < 32) cmd_sr = {cmd_sr[30:0], flash_mosi};
        bitcnt++;
    end
    always @(negedge flash_clk) if (!flash_csb && bitcnt >= 32) begin
        mk = bitcnt - 32;
        ma = cmd_sr[23:0] + 24'(mk / 8);
        mb = fbyte(ma);
        flash_miso = mb[7 - (mk % 8)];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Issue one bus access at a negedge, wait for mem_rdy, then check against the scoreboard.
    task automatic access(input string tag, input logic [31:0] addr, input bit wr, input int lat);
        exp_t e;
        bit   got;
        e.data = wr ? 32'h0 : exp_word(addr);
        e.lat  = lat;
        e.rd   = !wr;
        sb.push_back(e);
        mem_addr  = addr;
        mem_wstrb = wr ? 4'hF : 4'h0;
        mem_wdata = $urandom;
        mem_instr = !wr;
        mem_valid = 1'b1;
        csb_hi = 0; csb_lo = 0; n_cyc = 0; got = 0;
        while (!got && n_cyc < 400) begin
            @(negedge clk);
            n_cyc++;
            if (mem_rdy) got = 1;
            else if (flash_csb) csb_hi++;
            else csb_lo++;
        end
        mem_valid = 1'b0;
        mem_wstrb = 4'h0;
        chk($sformatf("%s_rdy", tag), 32'(got), 32'd1);
        e = sb.pop_front();
        chk($sformatf("%s_lat", tag), n_cyc, e.lat);
        if (e.rd) chk($sformatf("%s_data", tag), mem_rdata, e.data);
    endtask

    initial begin
        int rdy_seen, lo_seen;
        repeat (2) @(negedge clk);
        chk("rst_csb", 32'(flash_csb), 32'd1);
        chk("rst_sck", 32'(flash_clk), 32'd0);
        chk("rst_mosi", 32'(flash_mosi), 32'd0);
        chk("rst_rdy", 32'(mem_rdy), 32'd0);
        chk("rst_rdata", mem_rdata, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Outside the window: no response, no SPI activity.
        mem_addr = 32'h0100_0100; mem_valid = 1'b1;
        rdy_seen = 0; lo_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (mem_rdy) rdy_seen++;
            if (!flash_csb) lo_seen++;
        end
        mem_valid = 1'b0;
        chk("oow_rdy", rdy_seen, 0);
        chk("oow_csb", lo_seen, 0);
        @(negedge clk);

        access("rd100", 32'h0000_0100, 1'b0, 129);
        chk("rd100_val", mem_rdata, 32'h4433_2211);
        chk("rd100_cmd", cmd_sr, 32'h0300_0100);
        @(negedge clk);

        access("rd104", 32'h0000_0104, 1'b0, 65);
        chk("rd104_csb", csb_hi, 0);
        chk("rd104_cmd", cmd_sr, 32'h0300_0100);
        @(negedge clk);

        access("wrhold", 32'h0000_0300, 1'b1, 1);
        chk("wrhold_csbhi", csb_hi, 0);
        chk("wrhold_csbrdy", 32'(flash_csb), 32'd0);
        @(negedge clk);

        access("rd200", 32'h0000_0200, 1'b0, 131);
        chk("rd200_desel", csb_hi, 2);
        chk("rd200_cmd", cmd_sr, 32'h0300_0200);

        repeat (16) @(negedge clk);
        chk("hold_last_lo", 32'(flash_csb), 32'd0);
        @(negedge clk);
        chk("hold_timeout_hi", 32'(flash_csb), 32'd1);
        repeat (2) @(negedge clk);

        access("wridle", 32'h0000_0100, 1'b1, 1);
        chk("wridle_csb", csb_lo, 0);
        @(negedge clk);

        access("rdwrap", 32'h00FF_FFFC, 1'b0, 129);
        @(negedge clk);
        access("rdwrap0", 32'h0000_0000, 1'b0, 65);
        chk("rdwrap0_csb", csb_hi, 0);

        // Abort a read mid-DATA with an asynchronous reset while SCK is high.
        repeat (24) @(negedge clk);
        mem_addr = 32'h0000_0100; mem_wstrb = 4'h0; mem_valid = 1'b1;
        rdy_seen = 0;
        repeat (80) begin
            @(negedge clk);
            if (mem_rdy) rdy_seen++;
        end
        for (int i = 0; i < 4 && !flash_clk; i++) @(negedge clk);
        chk("abort_sck_pre", 32'(flash_clk), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_csb", 32'(flash_csb), 32'd1);
        chk("abort_sck", 32'(flash_clk), 32'd0);
        chk("abort_mosi", 32'(flash_mosi), 32'd0);
        chk("abort_rdy", 32'(mem_rdy), 32'd0);
        mem_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (mem_rdy) rdy_seen++;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (mem_rdy) rdy_seen++;
        end
        chk("abort_no_rdy", rdy_seen, 0);

        access("rdpost", 32'h0000_0100, 1'b0, 129);
        chk("rdpost_val", mem_rdata, 32'h4433_2211);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
